// File: rtl/tug_of_war_field.sv
// tug_of_war_field: parametrised tug-of-war playfield.
// One lit LED moves left on L presses and right on R presses. Pulling it off
// either end wins a round, then the field goes dark for HOLD_CYC cycles.
// The game ends when a score reaches WIN_SCORE.
// Optional feature macro: TUG_HEX_EN adds registered active-low 7-segment
// score outputs hex_l/hex_r.
module tug_of_war_field #(
    parameter int NUM_LIGHTS = 9,
    parameter int SCORE_W    = 3,
    parameter int WIN_SCORE  = 7,
    parameter int HOLD_CYC   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                L,
    input  logic                R,
    output logic [NUM_LIGHTS:1] LEDR,
    output logic [SCORE_W-1:0]  score_l,
    output logic [SCORE_W-1:0]  score_r,
    output logic                round_win_l,
    output logic                round_win_r,
    output logic                game_over
`ifdef TUG_HEX_EN
    ,
    output logic [6:0]          hex_l,
    output logic [6:0]          hex_r
`endif
);

    localparam int POS_W = $clog2(NUM_LIGHTS + 1);
    localparam int CNT_W = $clog2(HOLD_CYC + 1);
    localparam logic [POS_W-1:0]   POS_MAX   = POS_W'(NUM_LIGHTS);
    localparam logic [POS_W-1:0]   POS_MIN   = POS_W'(1);
    localparam logic [POS_W-1:0]   POS_CTR   = POS_W'((NUM_LIGHTS + 1) / 2);
    localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_HOLD = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t               r_state;
    logic [POS_W-1:0]     r_pos;
    logic [CNT_W-1:0]     r_cnt;
    logic [NUM_LIGHTS:1]  r_ledr;
    logic [SCORE_W-1:0]   r_score_l;
    logic [SCORE_W-1:0]   r_score_r;
    logic                 r_win_l;
    logic                 r_win_r;
    logic                 r_game_over;
    logic                 r_l_prev;
    logic                 r_r_prev;

    logic                 w_press_l;
    logic                 w_press_r;
    logic                 w_move_l;
    logic                 w_move_r;
    logic [POS_W-1:0]     w_pos_inc;
    logic [POS_W-1:0]     w_pos_dec;
    logic [SCORE_W-1:0]   w_score_l_inc;
    logic [SCORE_W-1:0]   w_score_r_inc;

    // Lamp pattern for a playfield position: exactly one bit set at index pos.
    function automatic logic [NUM_LIGHTS:1] f_onehot(input logic [POS_W-1:0] pos);
        logic [NUM_LIGHTS:1] v;
        v = {NUM_LIGHTS{1'b0}};
        for (int i = 1; i <= NUM_LIGHTS; i++) begin
            if (pos == POS_W'(i)) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    // Rising-edge press detection; simultaneous presses cancel out.
    assign w_press_l     = L & ~r_l_prev;
    assign w_press_r     = R & ~r_r_prev;
    assign w_move_l      = w_press_l & ~w_press_r;
    assign w_move_r      = w_press_r & ~w_press_l;
    assign w_pos_inc     = r_pos + POS_W'(1);
    assign w_pos_dec     = r_pos - POS_W'(1);
    assign w_score_l_inc = r_score_l + SCORE_W'(1);
    assign w_score_r_inc = r_score_r + SCORE_W'(1);

    // Press history, playfield movement, scoring and game phase sequencing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_PLAY;
            r_pos       <= POS_CTR;
            r_ledr      <= f_onehot(POS_CTR);
            r_cnt       <= CNT_W'(0);
            r_score_l   <= SCORE_W'(0);
            r_score_r   <= SCORE_W'(0);
            r_win_l     <= 1'b0;
            r_win_r     <= 1'b0;
            r_game_over <= 1'b0;
            r_l_prev    <= 1'b0;
            r_r_prev    <= 1'b0;
        end else begin
            r_l_prev <= L;
            r_r_prev <= R;
            r_win_l  <= 1'b0;
            r_win_r  <= 1'b0;
            case (r_state)
                ST_PLAY: begin
                    if (w_move_l) begin
                        if (r_pos == POS_MAX) begin
                            r_score_l <= w_score_l_inc;
                            r_win_l   <= 1'b1;
                            r_ledr    <= {NUM_LIGHTS{1'b0}};
                            if (w_score_l_inc == SCORE_WIN) begin
                                r_state     <= ST_OVER;
                                r_game_over <= 1'b1;
                            end else begin
                                r_state <= ST_HOLD;
                                r_cnt   <= CNT_LOAD;
                            end
                        end else begin
                            r_pos  <= w_pos_inc;
                            r_ledr <= f_onehot(w_pos_inc);
                        end
                    end else if (w_move_r) begin
                        if (r_pos == POS_MIN) begin
                            r_score_r <= w_score_r_inc;
                            r_win_r   <= 1'b1;
                            r_ledr    <= {NUM_LIGHTS{1'b0}};
                            if (w_score_r_inc == SCORE_WIN) begin
                                r_state     <= ST_OVER;
                                r_game_over <= 1'b1;
                            end else begin
                                r_state <= ST_HOLD;
                                r_cnt   <= CNT_LOAD;
                            end
                        end else begin
                            r_pos  <= w_pos_dec;
                            r_ledr <= f_onehot(w_pos_dec);
                        end
                    end else begin
                        r_ledr <= f_onehot(r_pos);
                    end
                end
                ST_HOLD: begin
                    // Counter was loaded with HOLD_CYC-1 on the win edge, so the
                    // field is dark for HOLD_CYC cycles in total.
                    if (r_cnt == CNT_W'(0)) begin
                        r_state <= ST_PLAY;
                        r_pos   <= POS_CTR;
                        r_ledr  <= f_onehot(POS_CTR);
                    end else begin
                        r_cnt  <= r_cnt - CNT_W'(1);
                        r_ledr <= {NUM_LIGHTS{1'b0}};
                    end
                end
                ST_OVER: begin
                    r_ledr      <= {NUM_LIGHTS{1'b0}};
                    r_game_over <= 1'b1;
                end
                default: begin
                    r_state <= ST_PLAY;
                    r_pos   <= POS_CTR;
                    r_ledr  <= f_onehot(POS_CTR);
                    r_cnt   <= CNT_W'(0);
                end
            endcase
        end
    end

    assign LEDR        = r_ledr;
    assign score_l     = r_score_l;
    assign score_r     = r_score_r;
    assign round_win_l = r_win_l;
    assign round_win_r = r_win_r;
    assign game_over   = r_game_over;

`ifdef TUG_HEX_EN
    logic [6:0] r_hex_l;
    logic [6:0] r_hex_r;

    // Active-low 7-segment glyphs 0-F, segment order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] f_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Score displays trail the score registers by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hex_l <= 7'b1000000;
            r_hex_r <= 7'b1000000;
        end else begin
            r_hex_l <= f_seg(4'(r_score_l));
            r_hex_r <= f_seg(4'(r_score_r));
        end
    end

    assign hex_l = r_hex_l;
    assign hex_r = r_hex_r;
`endif

endmodule

// File: tb/tb_tug_of_war_field.sv
// Scoreboard bench for tug_of_war_field (NUM_LIGHTS=9, WIN_SCORE=3, HOLD_CYC=4).
// The driver applies inputs, advances a behavioural game model on each rising
// edge and queues the expected outputs; the monitor pops and compares them
// on the falling edge.
module tb_tug_of_war_field;

    localparam int N    = 9;
    localparam int WIN  = 3;
    localparam int HOLD = 4;
    localparam int CTR  = 5;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       L     = 1'b0;
    logic       R     = 1'b0;
    logic [N:1] LEDR;
    logic [2:0] score_l;
    logic [2:0] score_r;
    logic       round_win_l;
    logic       round_win_r;
    logic       game_over;
`ifdef TUG_HEX_EN
    logic [6:0] hex_l;
    logic [6:0] hex_r;
`endif

    tug_of_war_field #(
        .NUM_LIGHTS(N), .SCORE_W(3), .WIN_SCORE(WIN), .HOLD_CYC(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .L(L), .R(R), .LEDR(LEDR),
        .score_l(score_l), .score_r(score_r),
        .round_win_l(round_win_l), .round_win_r(round_win_r),
        .game_over(game_over)
`ifdef TUG_HEX_EN
        , .hex_l(hex_l), .hex_r(hex_r)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] led;
        logic [2:0] sl;
        logic [2:0] sr;
        logic       wl;
        logic       wr;
        logic       go;
        logic [6:0] hl;
        logic [6:0] hr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural game state
    int         m_pos, m_sl, m_sr, m_dark;
    bit         m_over, m_lp, m_rp, m_wl, m_wr;
    logic [6:0] m_hl, m_hr;

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Advance the model by one rising edge and queue the resulting outputs.
    task automatic m_edge(input bit l, input bit r, input bit rstn);
        exp_t       e;
        bit         pl, pr;
        logic [8:0] one;
        if (!rstn) begin
            m_pos = CTR; m_sl = 0; m_sr = 0; m_dark = 0; m_over = 0;
            m_lp = 0; m_rp = 0; m_wl = 0; m_wr = 0;
            m_hl = glyph(0); m_hr = glyph(0);
        end else begin
            m_hl = glyph(m_sl);
            m_hr = glyph(m_sr);
            pl = l && !m_lp;
            pr = r && !m_rp;
            m_lp = l; m_rp = r;
            m_wl = 0; m_wr = 0;
            if (!m_over) begin
                if (m_dark > 0) begin
                    m_dark--;
                    if (m_dark == 0) m_pos = CTR;
                end else if (pl && !pr) begin
                    if (m_pos == N) begin
                        m_sl++; m_wl = 1;
                        if (m_sl == WIN) m_over = 1; else m_dark = HOLD;
                    end else m_pos++;
                end else if (pr && !pl) begin
                    if (m_pos == 1) begin
                        m_sr++; m_wr = 1;
                        if (m_sr == WIN) m_over = 1; else m_dark = HOLD;
                    end else m_pos--;
                end
            end
        end
        one   = 9'd1;
        e.led = (m_over || m_dark > 0) ? 9'd0 : (one << (m_pos - 1));
        e.sl  = 3'(m_sl);
        e.sr  = 3'(m_sr);
        e.wl  = m_wl;
        e.wr  = m_wr;
        e.go  = m_over;
        e.hl  = m_hl;
        e.hr  = m_hr;
        q.push_back(e);
    endtask

    // One clock cycle of stimulus; inputs change just after the falling edge.
    task automatic cyc(input bit l, input bit r, input bit rstn);
        @(negedge clk);
        #1;
        L = l; R = r; reset = rstn;
        @(posedge clk);
        m_edge(l, r, rstn);
    endtask

    // Assert reset between edges and confirm the asynchronous clear at once.
    task automatic async_reset(input string nm);
        @(negedge clk);
        #1;
        reset = 1'b0; L = 1'b0; R = 1'b0;
        #1;
        chk({nm, "_ledr"}, 32'(LEDR), 32'h010);
        chk({nm, "_score_l"}, 32'(score_l), 32'd0);
        chk({nm, "_score_r"}, 32'(score_r), 32'd0);
        chk({nm, "_game_over"}, 32'(game_over), 32'd0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: compare every DUT output against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ledr", 32'(LEDR), 32'(e.led));
                chk("score_l", 32'(score_l), 32'(e.sl));
                chk("score_r", 32'(score_r), 32'(e.sr));
                chk("round_win_l", 32'(round_win_l), 32'(e.wl));
                chk("round_win_r", 32'(round_win_r), 32'(e.wr));
                chk("game_over", 32'(game_over), 32'(e.go));
`ifdef TUG_HEX_EN
                chk("hex_l", 32'(hex_l), 32'(e.hl));
                chk("hex_r", 32'(hex_r), 32'(e.hr));
`endif
            end
        end
    end

    // Driver: directed scenarios followed by biased random play.
    initial begin
        int mode;
        bit l, r;
        m_edge(1'b0, 1'b0, 1'b0);
        void'(q.pop_back());
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
        repeat (5) cyc(1'b0, 1'b0, 1'b1);
        #1;
        chk("idle_centre", 32'(LEDR), 32'h010);

        // L held for six cycles gives a single step left
        repeat (6) cyc(1'b1, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        #1;
        chk("held_l_pos", 32'(LEDR), 32'h020);

        // Simultaneous press, then R presses from centre to a right win
        async_reset("rst_a");
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        repeat (5) begin
            cyc(1'b0, 1'b1, 1'b1);
            cyc(1'b0, 1'b0, 1'b1);
        end
        repeat (6) cyc(1'b0, 1'b0, 1'b1);

        // Left keeps pressing until the game ends, then R presses are ignored
        repeat (45) begin
            cyc(1'b1, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b1);
        end
        #1;
        chk("over_flag", 32'(game_over), 32'd1);
        chk("over_score_l", 32'(score_l), 32'(WIN));
        repeat (4) begin
            cyc(1'b0, 1'b1, 1'b1);
            cyc(1'b1, 1'b0, 1'b1);
        end

        // Reset in the middle of play at position 8
        async_reset("rst_over");
        repeat (3) begin
            cyc(1'b1, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b1);
        end
        #1;
        chk("pos8", 32'(LEDR), 32'h080);
        async_reset("rst_play8");

        // Reset in the middle of the dark hold period
        repeat (5) begin
            cyc(1'b0, 1'b1, 1'b1);
            cyc(1'b0, 1'b0, 1'b1);
        end
        cyc(1'b0, 1'b0, 1'b1);
        async_reset("rst_hold");

        // Biased random play with occasional resets
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) mode = int'($urandom_range(0, 2));
            case (mode)
                0: begin l = ($urandom_range(0, 1) == 1); r = ($urandom_range(0, 1) == 1); end
                1: begin l = ($urandom_range(0, 2) != 0); r = ($urandom_range(0, 7) == 0); end
                default: begin l = ($urandom_range(0, 7) == 0); r = ($urandom_range(0, 2) != 0); end
            endcase
            cyc(l, r, ($urandom_range(0, 399) != 0));
        end
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
